// File: rtl/elevator_pkg.sv
// Shared types and helpers for the four-floor elevator scheduler.
// Floor masks are one bit per floor, with bit n standing for floor n.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    localparam logic [1:0] FLOOR_0 = 2'd0;
    localparam logic [1:0] FLOOR_1 = 2'd1;
    localparam logic [1:0] FLOOR_2 = 2'd2;
    localparam logic [1:0] FLOOR_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } state_t;

    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    function automatic floor_mask_t floor_onehot(input logic [1:0] floor);
        floor_mask_t mask;
        mask        = '0;
        mask[floor] = 1'b1;
        return mask;
    endfunction

    function automatic logic calls_above(input floor_mask_t pend, input logic [1:0] floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i > int'(floor))) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    function automatic logic calls_below(input floor_mask_t pend, input logic [1:0] floor);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend[i] && (i < int'(floor))) begin
                found = 1'b1;
            end
        end
        return found;
    endfunction

    // "Ahead" means on the side the car is heading towards.
    function automatic logic calls_ahead(input floor_mask_t pend, input logic [1:0] floor,
                                         input logic up);
        return up ? calls_above(pend, floor) : calls_below(pend, floor);
    endfunction

    function automatic logic calls_behind(input floor_mask_t pend, input logic [1:0] floor,
                                          input logic up);
        return up ? calls_below(pend, floor) : calls_above(pend, floor);
    endfunction

endpackage

// File: rtl/elev_timer.sv
// Loadable down-counter whose done flag is raised while the count is zero.
// One instance is shared: it times travel between floors and door-open intervals.
module elev_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/elevator_scheduler.sv
// Single-car collective scheduler for four floors: latches calls, sweeps in one
// direction while calls lie ahead, and reverses only when idle or when the door closes.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] request,
    output logic [1:0] current_floor,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic       arrived,
    output logic [3:0] pending
);

    localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W   = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

    // The timer expires after load_val+1 cycles, so each load is one short of the duration.
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_floor;
    logic        r_dir_up;
    floor_mask_t r_pending;
    logic        r_arrived;

    state_t        w_state_next;
    logic [1:0]    w_floor_next;
    logic          w_dir_next;
    logic          w_arrived_next;
    floor_mask_t   w_served;
    floor_mask_t   w_calls;
    logic [1:0]    w_step_floor;
    logic          w_timer_load;
    logic [TIMER_W-1:0] w_timer_val;
    logic          w_timer_done;

    elev_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_done     (w_timer_done)
    );

    // A live request counts as a call at a floor the car is reaching this edge.
    assign w_calls      = r_pending | request;
    assign w_step_floor = (r_state == ST_MOVE_UP) ? (r_floor + 2'd1) : (r_floor - 2'd1);

    always_comb begin
        w_state_next   = r_state;
        w_floor_next   = r_floor;
        w_dir_next     = r_dir_up;
        w_arrived_next = 1'b0;
        w_served       = '0;
        w_timer_load   = 1'b0;
        w_timer_val    = TRAVEL_LOAD;

        case (r_state)
            ST_IDLE: begin
                if (w_calls[r_floor]) begin
                    w_state_next   = ST_DOOR_OPEN;
                    w_served       = floor_onehot(r_floor);
                    w_arrived_next = 1'b1;
                    w_timer_load   = 1'b1;
                    w_timer_val    = DOOR_LOAD;
                end else if (calls_ahead(r_pending, r_floor, r_dir_up)) begin
                    w_state_next = r_dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
                    w_timer_load = 1'b1;
                end else if (calls_behind(r_pending, r_floor, r_dir_up)) begin
                    w_dir_next   = ~r_dir_up;
                    w_state_next = r_dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
                    w_timer_load = 1'b1;
                end
            end

            ST_MOVE_UP, ST_MOVE_DOWN: begin
                if (w_timer_done) begin
                    w_floor_next = w_step_floor;
                    if (w_calls[w_step_floor]) begin
                        w_state_next   = ST_DOOR_OPEN;
                        w_served       = floor_onehot(w_step_floor);
                        w_arrived_next = 1'b1;
                        w_timer_load   = 1'b1;
                        w_timer_val    = DOOR_LOAD;
                    end else if (calls_ahead(r_pending, w_step_floor, r_dir_up)) begin
                        w_timer_load = 1'b1;
                    end else begin
                        // Cannot happen while a call drew the car this way; park safely.
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                w_served = floor_onehot(r_floor);
                if (request[r_floor]) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = DOOR_LOAD;
                end else if (w_timer_done) begin
                    if (calls_ahead(r_pending, r_floor, r_dir_up)) begin
                        w_state_next = r_dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
                        w_timer_load = 1'b1;
                    end else if (calls_behind(r_pending, r_floor, r_dir_up)) begin
                        w_dir_next   = ~r_dir_up;
                        w_state_next = r_dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
                        w_timer_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_floor   <= FLOOR_0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
            r_arrived <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_floor   <= w_floor_next;
            r_dir_up  <= w_dir_next;
            r_pending <= (r_pending | request) & ~w_served;
            r_arrived <= w_arrived_next;
        end
    end

    assign current_floor = r_floor;
    assign moving        = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DOWN);
    assign door_open     = (r_state == ST_DOOR_OPEN);
    assign dir_up        = r_dir_up;
    assign arrived       = r_arrived;
    assign pending       = r_pending;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls, every cycle
// compared against a floor/elapsed-time reference model of the scheduling rules.
module tb_elevator_scheduler;

    localparam int TRAVEL = 8;
    localparam int DOOR   = 4;

    localparam int M_IDLE   = 0;
    localparam int M_MOVING = 1;
    localparam int M_DOOR   = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] request = 4'b0000;
    logic [1:0] current_floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic       arrived;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: floor number, travel direction, activity, cycles spent in it.
    int       m_floor;
    bit       m_up;
    int       m_mode;
    int       m_elapsed;
    bit [3:0] m_pend;
    bit       m_arr;

    elevator_scheduler #(
        .TRAVEL_CYCLES (TRAVEL),
        .DOOR_CYCLES   (DOOR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .request       (request),
        .current_floor (current_floor),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .arrived       (arrived),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit any_call(input bit [3:0] p, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i <= 3 && p[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ahead_of(input bit [3:0] p, input int f, input bit up);
        return up ? any_call(p, f + 1, 3) : any_call(p, 0, f - 1);
    endfunction

    task automatic model_reset();
        m_floor   = 0;
        m_up      = 1'b1;
        m_mode    = M_IDLE;
        m_elapsed = 0;
        m_pend    = 4'b0000;
        m_arr     = 1'b0;
    endtask

    task automatic open_door_at_floor(inout bit [3:0] served);
        m_mode          = M_DOOR;
        m_elapsed       = 0;
        served[m_floor] = 1'b1;
        m_arr           = 1'b1;
    endtask

    task automatic leave_or_park();
        m_elapsed = 0;
        if (ahead_of(m_pend, m_floor, m_up)) begin
            m_mode = M_MOVING;
        end else if (ahead_of(m_pend, m_floor, !m_up)) begin
            m_up   = !m_up;
            m_mode = M_MOVING;
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic model_step(input bit [3:0] req);
        bit [3:0] calls;
        bit [3:0] served;
        calls  = m_pend | req;
        served = 4'b0000;
        m_arr  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (calls[m_floor]) open_door_at_floor(served);
                else leave_or_park();
            end
            M_MOVING: begin
                m_elapsed++;
                if (m_elapsed == TRAVEL) begin
                    m_floor   = m_floor + (m_up ? 1 : -1);
                    m_elapsed = 0;
                    if (calls[m_floor]) open_door_at_floor(served);
                    else if (!ahead_of(m_pend, m_floor, m_up)) m_mode = M_IDLE;
                end
            end
            default: begin
                served[m_floor] = 1'b1;
                if (req[m_floor]) begin
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == DOOR) leave_or_park();
                end
            end
        endcase
        m_pend = (m_pend | req) & ~served;
    endtask

    task automatic compare_all();
        check("floor",   32'(current_floor), 32'(m_floor));
        check("moving",  32'(moving),        32'(m_mode == M_MOVING));
        check("door",    32'(door_open),     32'(m_mode == M_DOOR));
        check("dir_up",  32'(dir_up),        32'(m_up));
        check("arrived", 32'(arrived),       32'(m_arr));
        check("pending", 32'(pending),       32'(m_pend));
    endtask

    task automatic drive(input bit [3:0] req, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            request = req;
            @(posedge clk);
            cyc++;
            model_step(req);
            #1;
            compare_all();
        end
    endtask

    // Reset lands mid-cycle so the outputs must clear without any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        request = 4'b0000;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit [3:0] rq;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Single call two floors up: exact timing of travel, arrival and door.
        drive(4'b0100, 1);
        drive(4'b0000, 17);
        check("t_arrive_pulse", 32'(arrived), 32'd1);
        check("t_arrive_floor", 32'(current_floor), 32'd2);
        check("t_door_open", 32'(door_open), 32'd1);
        drive(4'b0000, 3);
        check("t_door_last", 32'(door_open), 32'd1);
        drive(4'b0000, 1);
        check("t_idle_after", 32'({moving, door_open}), 32'd0);

        // Calls at 1 and 3 from floor 0: stop at 1, pass 2, stop at 3.
        async_reset();
        drive(4'b1010, 1);
        drive(4'b0000, 40);
        check("sweep_pending", 32'(pending), 32'd0);
        check("sweep_floor", 32'(current_floor), 32'd3);

        // Calls behind and ahead while travelling 1 -> 2.
        async_reset();
        drive(4'b0100, 1);
        drive(4'b0000, 10);
        drive(4'b1001, 1);
        drive(4'b0000, 90);
        check("rev_pending", 32'(pending), 32'd0);
        check("rev_floor", 32'(current_floor), 32'd0);

        // Held call at the floor where the car is parked keeps the door open.
        drive(4'b0100, 1);
        drive(4'b0000, 30);
        drive(4'b0100, 10);
        check("hold_door", 32'(door_open), 32'd1);
        drive(4'b0000, 3);
        check("hold_door_tail", 32'(door_open), 32'd1);
        drive(4'b0000, 1);
        check("hold_idle", 32'(door_open), 32'd0);

        // Reset in the middle of 1 -> 2 with a call latched for floor 3.
        async_reset();
        drive(4'b1000, 1);
        drive(4'b0000, 12);
        check("mid_moving", 32'(moving), 32'd1);
        async_reset();
        drive(4'b0000, 20);
        check("post_rst_floor", 32'(current_floor), 32'd0);
        check("post_rst_moving", 32'(moving), 32'd0);

        // Random sparse calls, then drain until every call has been served.
        for (int n = 0; n < 5000; n++) begin
            rq = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            drive(rq, 1);
        end
        drive(4'b0000, 200);
        check("drain_pending", 32'(pending), 32'd0);
        check("drain_moving", 32'(moving), 32'd0);
        check("drain_door", 32'(door_open), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter: TRAVEL_CYCLES, 8, clock cycles to travel between adjacent floors (>=2).
REQ-002 Parameter: DOOR_CYCLES, 4, clock cycles the door stays open per stop (>=2).
REQ-003 Port: clk  input  1  single clock; all flops on rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: request  input  4  per-floor call, bit n = floor n, level-sampled each cycle, multiple bits allowed.
REQ-006 Port: current_floor  output  2  last floor reached (0..3).
REQ-007 Port: moving  output  1  high in MOVE_UP/MOVE_DOWN.
REQ-008 Port: dir_up  output  1  current/last travel direction, 1 = up.
REQ-009 Port: door_open  output  1  high in DOOR_OPEN.
REQ-010 Port: arrived  output  1  one-cycle pulse on the cycle DOOR_OPEN is entered.
REQ-011 Port: pending  output  4  latched unserved calls.

Function
REQ-012 pending SHALL update each edge as (pending | request) & ~served, served = one-hot of floor cleared that cycle.
REQ-013 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; moving/door_open are decoded from state only.
REQ-014 "ahead" = any pending bit above current_floor when dir_up=1, below when dir_up=0; "behind" = opposite side.
REQ-015 IDLE: pending bit at current_floor (or request bit at current_floor) SHALL enter DOOR_OPEN next edge, clear that bit, pulse arrived.
REQ-016 IDLE, no call at current_floor: ahead -> move in dir_up; else behind -> invert dir_up and move; else stay IDLE.
REQ-017 Entering MOVE_* SHALL load the travel timer; after exactly TRAVEL_CYCLES cycles in MOVE_* current_floor SHALL step by +/-1.
REQ-018 On floor step: if pending (or request) at new floor -> DOOR_OPEN same edge, bit cleared, arrived pulsed; else continue same direction, timer reloaded.
REQ-019 DOOR_OPEN SHALL last DOOR_CYCLES cycles; a request for current_floor during DOOR_OPEN SHALL be absorbed (not latched) and reload the door timer.
REQ-020 DOOR_OPEN expiry: ahead -> continue; else behind -> reverse; else IDLE.
REQ-021 Calls at the just-departed floor during MOVE_* SHALL be latched and served on a later pass, never by reversing mid-travel.
REQ-022 current_floor SHALL never exceed 3 or go below 0; MOVE_UP from 3 or MOVE_DOWN from 0 is unreachable (assertion).
REQ-023 Direction SHALL change only in IDLE or at DOOR_OPEN expiry.

Reset
REQ-024 reset_n low SHALL immediately force: state IDLE, current_floor 0, dir_up 1, pending 0, timers 0, moving 0, door_open 0, arrived 0.
REQ-025 Reset asserted mid-travel or door-open SHALL discard all pending calls; first post-release edge behaves as IDLE at floor 0.

Structure
REQ-026 Shared package elevator_pkg SHALL hold NUM_FLOORS=4, floor constants FLOOR_0..FLOOR_3, and the state enum type.
REQ-027 One sub-module elev_timer (loadable down-counter with done flag) SHALL be instantiated once, shared by travel and door timing.

Verification
REQ-028 Reset, then request=4'b0100 one cycle at edge k -> MOVE_UP at k+1, current_floor 1 at k+9, 2 at k+17 with arrived, door_open k+17..k+20, IDLE k+21.
REQ-029 At floor 0 request 4'b1010 -> stop at 1 (door 4 cycles), continue to 3 without stopping at 2, pending 0 afterwards.
REQ-030 Moving up from 1 to 2, request floor 0 and floor 3 -> serves 2 (if pending) then 3, reverses only at 3, then serves 0.
REQ-031 Idle at 2, request 4'b0100 held 10 cycles -> door_open held continuously, pending[2] never set, IDLE 4 cycles after release.
REQ-032 reset_n pulsed low mid-travel 1->2 with pending 4'b1000 -> outputs zeroed asynchronously, pending 0, floor 0, no movement after release.
REQ-033 Random requests 5000 cycles -> assertions: floor within 0..3, step only after TRAVEL_CYCLES, no direction change while moving, every call eventually arrived.
